// File: rtl/distri_ram_dump_pkg.sv
// distri_ram_dump_pkg
//   Shared definitions for the distri_ram dump engine.
//   state_e : 2-bit FSM encoding.
//     S_IDLE  - waiting for start_i
//     S_RUN   - walking the RAM and loading the output register
//     S_DRAIN - last entry loaded; waiting for its handshake
package distri_ram_dump_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/distri_ram_dump.sv
// distri_ram_dump
//   Streams every entry of a distri_ram, from index 0 to ENTRY_NUM-1, over a
//   valid/ready stream. When clear_i is set with start_i, each entry is
//   written to zero in the same cycle it is accepted downstream.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i, clear_i start a dump when idle; clear_i selects zero-on-accept
//   busy_o, done_o   dump in progress; one-cycle completion pulse
//   ram_raddr_o      read address (combinational read data on ram_rdata_i)
//   ram_we_o, ram_waddr_o, ram_wdata_o   clear write port (data always 0)
//   m_valid_o, m_ready_i, m_data_o, m_index_o, m_last_o   output stream
//
// Stream handshake: an entry transfers on every rising edge where
// m_valid_o and m_ready_i are both high. Once m_valid_o is raised, it and all
// m_* payload outputs stay stable until that transfer; m_ready_i may change
// freely and has no combinational path to m_valid_o.
module distri_ram_dump
  import distri_ram_dump_pkg::*;
#(
  parameter int ENTRY_NUM = 32,
  parameter int XLEN      = 64,
  parameter int AWIDTH    = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] ram_raddr_o,
  input  logic [XLEN-1:0]   ram_rdata_i,
  output logic              ram_we_o,
  output logic [AWIDTH-1:0] ram_waddr_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [XLEN-1:0]   m_data_o,
  output logic [AWIDTH-1:0] m_index_o,
  output logic              m_last_o
);

  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(ENTRY_NUM - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] rd_ptr;
  logic              clear_q;
  logic              load;
  logic              hs;
  logic              ptr_at_last;

  assign hs          = m_valid_o & m_ready_i;
  assign ptr_at_last = (rd_ptr == LAST_IDX);
  // The output register can take a new entry when it is empty or its
  // current entry is leaving this cycle.
  assign load        = (state_q == S_RUN) & (~m_valid_o | m_ready_i);

  assign ram_raddr_o = rd_ptr;
  // Clearing on the handshake cycle guarantees an entry is captured before
  // it is zeroed.
  assign ram_we_o    = hs & clear_q;
  assign ram_waddr_o = m_index_o;
  assign ram_wdata_o = '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (load && ptr_at_last) state_d = S_DRAIN;
      S_DRAIN: if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rd_ptr    <= '0;
      clear_q   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_index_o <= '0;
      m_last_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;

      if (state_q == S_IDLE && start_i) begin
        rd_ptr  <= '0;
        clear_q <= clear_i;
        busy_o  <= 1'b1;
      end

      if (load) begin
        m_data_o  <= ram_rdata_i;
        m_index_o <= rd_ptr;
        m_last_o  <= ptr_at_last;
        m_valid_o <= 1'b1;
        // Pointer parks on the last index so it never reaches ENTRY_NUM.
        if (!ptr_at_last) rd_ptr <= rd_ptr + 1'b1;
      end else if (hs) begin
        m_valid_o <= 1'b0;
      end

      if (state_q == S_DRAIN && hs) begin
        busy_o <= 1'b0;
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_distri_ram_dump.sv
// tb_distri_ram_dump
//   Directed bench for distri_ram_dump. Two instances: a 32-entry one and a
//   5-entry one, each paired with a behavioural distri_ram (combinational
//   read, registered write) that the bench can also preload.
module tb_distri_ram_dump;

  localparam int XLEN = 64;
  localparam int N_A  = 32;
  localparam int AW_A = 5;
  localparam int N_B  = 5;
  localparam int AW_B = 3;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  // DUT A signals
  logic            start_i, clear_i, m_ready_i;
  logic            busy_o, done_o, ram_we_o, m_valid_o, m_last_o;
  logic [AW_A-1:0] ram_raddr_o, ram_waddr_o, m_index_o;
  logic [XLEN-1:0] ram_rdata_i, ram_wdata_o, m_data_o;

  // DUT B signals
  logic            start_b, ready_b;
  logic            busy_b, done_b, we_b, valid_b, last_b;
  logic [AW_B-1:0] raddr_b, waddr_b, index_b;
  logic [XLEN-1:0] rdata_b, wdata_b, data_b;

  // bench preload port shared by both RAM models
  logic            tb_we;
  logic [4:0]      tb_addr;
  logic [XLEN-1:0] tb_data;

  logic [XLEN-1:0] ram_a [N_A];
  logic [XLEN-1:0] ram_b [N_B];

  assign ram_rdata_i = ram_a[ram_raddr_o];
  assign rdata_b     = (int'(raddr_b) < N_B) ? ram_b[raddr_b] : '0;

  always @(posedge clk_i) begin
    if (tb_we) ram_a[tb_addr] <= tb_data;
    else if (ram_we_o) ram_a[ram_waddr_o] <= ram_wdata_o;
    if (tb_we && tb_addr < 5'(N_B)) ram_b[tb_addr[AW_B-1:0]] <= tb_data + 64'd100;
    else if (we_b && int'(waddr_b) < N_B) ram_b[waddr_b] <= wdata_b;
  end

  distri_ram_dump #(.ENTRY_NUM(N_A), .XLEN(XLEN), .AWIDTH(AW_A)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .busy_o(busy_o), .done_o(done_o), .ram_raddr_o(ram_raddr_o),
    .ram_rdata_i(ram_rdata_i), .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o),
    .ram_wdata_o(ram_wdata_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_index_o(m_index_o), .m_last_o(m_last_o)
  );

  distri_ram_dump #(.ENTRY_NUM(N_B), .XLEN(XLEN), .AWIDTH(AW_B)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b), .clear_i(1'b0),
    .busy_o(busy_b), .done_o(done_b), .ram_raddr_o(raddr_b),
    .ram_rdata_i(rdata_b), .ram_we_o(we_b), .ram_waddr_o(waddr_b),
    .ram_wdata_o(wdata_b), .m_valid_o(valid_b), .m_ready_i(ready_b),
    .m_data_o(data_b), .m_index_o(index_b), .m_last_o(last_b)
  );

  // scoreboard state
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] got_data[$];
  logic [AW_A-1:0] got_idx[$];
  logic            got_last[$];
  logic [AW_A-1:0] we_addr_q[$];
  int done_cnt, stall_errs, stall_cnt, wdata_errs, first_cyc, last_cyc, done_cyc;
  bit timed_out;

  // driver tasks
  task automatic preload();
    for (int i = 0; i < N_A; i++) begin
      tb_we = 1'b1; tb_addr = 5'(i); tb_data = 64'(i * 3);
      @(posedge clk_i); #1;
    end
    tb_we = 1'b0;
  endtask

  task automatic start_dump(input logic clr);
    start_i = 1'b1; clear_i = clr;
    @(posedge clk_i); #1;
    start_i = 1'b0; clear_i = 1'b0;
  endtask

  // Runs the consumer side of one dump. mode 0: ready always high; mode 1:
  // ready follows 1,0,0,1. restart_beat re-pulses start_i after that many
  // beats; reset_beat pulls reset when that index is presented.
  task automatic collect(input int mode, input int restart_beat, input int reset_beat);
    logic prev_v, prev_r;
    logic [XLEN-1:0] prev_d;
    logic [AW_A-1:0] prev_i;
    bit seen_done;
    int tail;
    got_data.delete(); got_idx.delete(); got_last.delete(); we_addr_q.delete();
    done_cnt = 0; stall_errs = 0; stall_cnt = 0; wdata_errs = 0; timed_out = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    prev_v = 0; prev_r = 0; prev_d = '0; prev_i = '0; seen_done = 0; tail = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk_i); #1;
      if (done_o) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; seen_done = 1; end
      if (prev_v && !prev_r) begin
        stall_cnt++;
        if (!(m_valid_o && m_data_o === prev_d && m_index_o === prev_i)) stall_errs++;
      end
      if (reset_beat >= 0 && m_valid_o && m_index_o == 5'(reset_beat)) begin
        m_ready_i = 1'b0; rst_ni = 1'b0;
        return;
      end
      start_i = 1'b0;
      m_ready_i = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (m_valid_o && first_cyc < 0) first_cyc = cyc;
      if (ram_we_o) begin
        we_addr_q.push_back(ram_waddr_o);
        if (ram_wdata_o !== '0) wdata_errs++;
      end
      if (m_valid_o && m_ready_i) begin
        got_data.push_back(m_data_o); got_idx.push_back(m_index_o); got_last.push_back(m_last_o);
        last_cyc = cyc;
        if (got_data.size() == restart_beat) start_i = 1'b1;
      end
      prev_v = m_valid_o; prev_r = m_ready_i; prev_d = m_data_o; prev_i = m_index_o;
      if (seen_done) begin tail++; if (tail == 3) return; end
    end
    timed_out = 1;
  endtask

  // scenarios
  task automatic test_reset();
    chk_cnt++; if (m_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", m_valid_o); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", busy_o); else pass_cnt++;
    chk_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done: got %0b exp 0", done_o); else pass_cnt++;
    chk_cnt++; if (ram_we_o !== 1'b0) $display("FAIL reset_we: got %0b exp 0", ram_we_o); else pass_cnt++;
    chk_cnt++; if ({m_data_o, m_index_o, m_last_o} !== '0) $display("FAIL reset_payload: got data %0h idx %0d last %0b exp 0", m_data_o, m_index_o, m_last_o); else pass_cnt++;
    chk_cnt++; if (ram_raddr_o !== '0) $display("FAIL reset_raddr: got %0d exp 0", ram_raddr_o); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] e;
    preload();
    start_dump(1'b0);
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL stream_busy_start: got %0b exp 1", busy_o); else pass_cnt++;
    chk_cnt++; if (m_valid_o !== 1'b0) $display("FAIL stream_valid_early: got %0b exp 0", m_valid_o); else pass_cnt++;
    collect(0, -1, -1);
    chk_cnt++; if (timed_out) $display("FAIL stream_timeout: got timeout exp done"); else pass_cnt++;
    chk_cnt++; if (got_data.size() !== 32) $display("FAIL stream_beats: got %0d exp 32", got_data.size()); else pass_cnt++;
    for (int i = 0; i < N_A; i++) exp_q.push_back(64'(i * 3));
    for (int i = 0; i < got_data.size() && i < N_A; i++) begin
      e = exp_q.pop_front();
      chk_cnt++; if (got_data[i] !== e) $display("FAIL stream_data[%0d]: got %0h exp %0h", i, got_data[i], e); else pass_cnt++;
      chk_cnt++; if (got_idx[i] !== 5'(i)) $display("FAIL stream_idx[%0d]: got %0d exp %0d", i, got_idx[i], i); else pass_cnt++;
      chk_cnt++; if (got_last[i] !== (i == N_A - 1)) $display("FAIL stream_last[%0d]: got %0b exp %0b", i, got_last[i], i == N_A - 1); else pass_cnt++;
    end
    exp_q.delete();
    chk_cnt++; if (first_cyc !== 0) $display("FAIL stream_first_latency: got %0d exp 0", first_cyc); else pass_cnt++;
    chk_cnt++; if (last_cyc !== 31) $display("FAIL stream_last_cycle: got %0d exp 31", last_cyc); else pass_cnt++;
    chk_cnt++; if (done_cyc !== 32) $display("FAIL stream_done_cycle: got %0d exp 32", done_cyc); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL stream_done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (we_addr_q.size() !== 0) $display("FAIL stream_no_writes: got %0d exp 0", we_addr_q.size()); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL stream_busy_end: got %0b exp 0", busy_o); else pass_cnt++;
    for (int i = 0; i < N_A; i++) begin
      chk_cnt++; if (ram_a[i] !== 64'(i * 3)) $display("FAIL stream_ram[%0d]: got %0h exp %0h", i, ram_a[i], i * 3); else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    preload();
    start_dump(1'b1);
    collect(0, -1, -1);
    chk_cnt++; if (timed_out) $display("FAIL clear_timeout: got timeout exp done"); else pass_cnt++;
    chk_cnt++; if (got_data.size() !== 32) $display("FAIL clear_beats: got %0d exp 32", got_data.size()); else pass_cnt++;
    for (int i = 0; i < got_data.size() && i < N_A; i++) begin
      chk_cnt++; if (got_data[i] !== 64'(i * 3)) $display("FAIL clear_data[%0d]: got %0h exp %0h", i, got_data[i], i * 3); else pass_cnt++;
    end
    chk_cnt++; if (we_addr_q.size() !== 32) $display("FAIL clear_we_count: got %0d exp 32", we_addr_q.size()); else pass_cnt++;
    for (int i = 0; i < we_addr_q.size() && i < N_A; i++) begin
      chk_cnt++; if (we_addr_q[i] !== 5'(i)) $display("FAIL clear_waddr[%0d]: got %0d exp %0d", i, we_addr_q[i], i); else pass_cnt++;
    end
    chk_cnt++; if (wdata_errs !== 0) $display("FAIL clear_wdata: got %0d nonzero writes exp 0", wdata_errs); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL clear_done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    for (int i = 0; i < N_A; i++) begin
      chk_cnt++; if (ram_a[i] !== '0) $display("FAIL clear_ram[%0d]: got %0h exp 0", i, ram_a[i]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    preload();
    start_dump(1'b0);
    collect(1, -1, -1);
    chk_cnt++; if (timed_out) $display("FAIL bp_timeout: got timeout exp done"); else pass_cnt++;
    chk_cnt++; if (got_data.size() !== 32) $display("FAIL bp_beats: got %0d exp 32", got_data.size()); else pass_cnt++;
    for (int i = 0; i < got_data.size() && i < N_A; i++) begin
      chk_cnt++; if (got_idx[i] !== 5'(i) || got_data[i] !== 64'(i * 3)) $display("FAIL bp_beat[%0d]: got idx %0d data %0h exp idx %0d data %0h", i, got_idx[i], got_data[i], i, i * 3); else pass_cnt++;
    end
    chk_cnt++; if (stall_cnt < 16) $display("FAIL bp_stalls_seen: got %0d exp >=16", stall_cnt); else pass_cnt++;
    chk_cnt++; if (stall_errs !== 0) $display("FAIL bp_stable: got %0d unstable stalls exp 0", stall_errs); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL bp_done_count: got %0d exp 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    preload();
    start_dump(1'b0);
    collect(0, 10, -1);
    chk_cnt++; if (timed_out) $display("FAIL restart_timeout: got timeout exp done"); else pass_cnt++;
    chk_cnt++; if (got_data.size() !== 32) $display("FAIL restart_beats: got %0d exp 32", got_data.size()); else pass_cnt++;
    for (int i = 0; i < got_data.size() && i < N_A; i++) begin
      chk_cnt++; if (got_idx[i] !== 5'(i)) $display("FAIL restart_idx[%0d]: got %0d exp %0d", i, got_idx[i], i); else pass_cnt++;
    end
    chk_cnt++; if (done_cnt !== 1) $display("FAIL restart_done_count: got %0d exp 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // start_i held in the done_o cycle must launch a new dump.
    int cyc;
    preload();
    start_dump(1'b0);
    m_ready_i = 1'b1;
    cyc = 0;
    while (!done_o && cyc < 100) begin @(posedge clk_i); #1; cyc++; end
    chk_cnt++; if (done_o !== 1'b1) $display("FAIL b2b_done_seen: got %0b exp 1", done_o); else pass_cnt++;
    start_dump(1'b0);
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL b2b_restart_busy: got %0b exp 1", busy_o); else pass_cnt++;
    collect(0, -1, -1);
    chk_cnt++; if (got_data.size() !== 32 || done_cnt !== 1) $display("FAIL b2b_second_dump: got beats %0d done %0d exp 32 1", got_data.size(), done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dn;
    preload();
    start_dump(1'b1);
    collect(0, -1, 5);
    #1;
    chk_cnt++; if (rst_ni !== 1'b0) $display("FAIL rstmid_reached: got beat 5 not presented exp presented"); else pass_cnt++;
    chk_cnt++; if ({m_valid_o, busy_o, done_o, ram_we_o, m_last_o} !== 5'b0) $display("FAIL rstmid_ctrl: got v%0b b%0b d%0b we%0b l%0b exp 0", m_valid_o, busy_o, done_o, ram_we_o, m_last_o); else pass_cnt++;
    chk_cnt++; if ({m_data_o, m_index_o} !== '0) $display("FAIL rstmid_payload: got %0h/%0d exp 0", m_data_o, m_index_o); else pass_cnt++;
    chk_cnt++; if (we_addr_q.size() !== 5) $display("FAIL rstmid_writes: got %0d exp 5", we_addr_q.size()); else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk_i); #1; if (done_o) dn++; end
    chk_cnt++; if (dn !== 0) $display("FAIL rstmid_no_done: got %0d exp 0", dn); else pass_cnt++;
    for (int i = 0; i < N_A; i++) begin
      chk_cnt++; if (ram_a[i] !== ((i < 5) ? 64'd0 : 64'(i * 3))) $display("FAIL rstmid_ram[%0d]: got %0h exp %0h", i, ram_a[i], (i < 5) ? 0 : i * 3); else pass_cnt++;
    end
  endtask

  task automatic test_small();
    int beats, dn, bad_ptr, cyc;
    bit seen;
    preload();
    ready_b = 1'b1;
    start_b = 1'b1; @(posedge clk_i); #1; start_b = 1'b0;
    beats = 0; dn = 0; bad_ptr = 0; seen = 0;
    for (cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(posedge clk_i); #1;
      if (done_b) begin dn++; seen = 1; end
      if (int'(raddr_b) > N_B - 1) bad_ptr++;
      if (valid_b) begin
        chk_cnt++; if (index_b !== 3'(beats) || data_b !== 64'(beats * 3 + 100) || last_b !== (beats == N_B - 1)) $display("FAIL small_beat[%0d]: got idx %0d data %0h last %0b exp idx %0d data %0h last %0b", beats, index_b, data_b, last_b, beats, beats * 3 + 100, beats == N_B - 1); else pass_cnt++;
        beats++;
      end
    end
    chk_cnt++; if (beats !== 5) $display("FAIL small_beats: got %0d exp 5", beats); else pass_cnt++;
    chk_cnt++; if (dn !== 1) $display("FAIL small_done: got %0d exp 1", dn); else pass_cnt++;
    chk_cnt++; if (bad_ptr !== 0) $display("FAIL small_ptr_range: got %0d exp 0", bad_ptr); else pass_cnt++;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; m_ready_i = 1'b0;
    start_b = 1'b0; ready_b = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_stream();
    test_clear();
    test_backpressure();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/distri_ram_dump.md
Name: distri_ram_dump

Overview:
- Read-side engine that streams every entry of a distri_ram instance, from index 0 to ENTRY_NUM-1, out over a valid/ready stream.
- Optionally zeroes each entry through the RAM write port once that entry has been accepted.
- Used for cache tag/dirty-array flush, debug dump of small tables, and bulk clear after reset.
- Sits between a distri_ram and a downstream consumer such as a flush FSM or debug bridge.

Parameters:
- ENTRY_NUM, 32, number of RAM entries to dump (need not be a power of two).
- XLEN, 64, entry data width.
- AWIDTH, $clog2(ENTRY_NUM), RAM address width.

Ports:
- clk_i  input  1  core clock; all logic on posedge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  pulse; begins a dump when idle.
- clear_i  input  1  sampled with start_i; 1 = zero each entry after it is accepted.
- busy_o  output  1  high from the cycle after start until done.
- done_o  output  1  one-cycle pulse when the dump completes.
- ram_raddr_o  output  AWIDTH  RAM read address.
- ram_rdata_i  input  XLEN  RAM read data, combinational from ram_raddr_o.
- ram_we_o  output  1  RAM write enable (clear writes).
- ram_waddr_o  output  AWIDTH  RAM write address.
- ram_wdata_o  output  XLEN  RAM write data; constant 0.
- m_valid_o  output  1  output entry valid.
- m_ready_i  input  1  consumer accepts the entry.
- m_data_o  output  XLEN  entry data.
- m_index_o  output  AWIDTH  entry index.
- m_last_o  output  1  entry is index ENTRY_NUM-1.

Behaviour:
- States:
  - IDLE: wait for start_i.
  - RUN: stream entries.
  - DRAIN: last entry has been loaded; wait for its handshake.
- Reset: state IDLE. rd_ptr, clear_q, busy_o, done_o, m_valid_o, m_data_o, m_index_o, m_last_o and ram_we_o all 0.
- Start:
  - IDLE & start_i: rd_ptr<=0, clear_q<=clear_i, state<=RUN, busy_o<=1.
  - start_i outside IDLE is ignored.
- Read address: ram_raddr_o = rd_ptr at all times.
- Load condition: load = (state==RUN) & (!m_valid_o | m_ready_i).
- On load:
  - m_data_o<=ram_rdata_i, m_index_o<=rd_ptr, m_last_o<=(rd_ptr==ENTRY_NUM-1), m_valid_o<=1.
  - If rd_ptr==ENTRY_NUM-1, state<=DRAIN; otherwise rd_ptr<=rd_ptr+1.
  - rd_ptr never wraps and never reaches ENTRY_NUM.
- Handshake without load: m_valid_o & m_ready_i & !load -> m_valid_o<=0.
- Throughput: one entry per cycle while m_ready_i is held high.
  - First m_valid_o is 2 cycles after the start_i cycle (RUN entry, then load).
- Backpressure:
  - While m_valid_o & !m_ready_i, all m_* outputs hold stable and rd_ptr holds.
- Clear path:
  - ram_we_o = m_valid_o & m_ready_i & clear_q, combinational.
  - ram_waddr_o = m_index_o.
  - Each entry is written 0 only in its own handshake cycle, so no entry is cleared before it is captured.
- Completion:
  - DRAIN & m_ready_i (with m_valid_o high): m_valid_o<=0, state<=IDLE, busy_o<=0.
  - done_o<=1 in that same edge, for exactly one cycle.
- Back-to-back: start_i in the cycle done_o is high is accepted (state is IDLE).
- ENTRY_NUM==1: the first load goes directly to DRAIN with m_last_o=1.
- Reset mid-dump: all state returns to reset values immediately; a partially cleared RAM is left as is; no done_o is issued.
- External writes to the same RAM during a dump are the integrator's responsibility. Entries are captured as they are at their load cycle.

Decomposition:
- Shared package: state encoding constants S_IDLE/S_RUN/S_DRAIN (2-bit).
- No sub-module: the output register stage is inline.
- The bench instantiates distri_ram alongside the DUT, connected through the ram_* ports.

Test Plan:
- ENTRY_NUM=32, RAM[i]=i*3, start_i with clear_i=0, m_ready_i=1 -> 32 beats on consecutive cycles, data 0,3,...,93, m_last_o only on index 31, done_o 1 cycle after the last beat, RAM unchanged.
- Same preload with clear_i=1 -> identical stream; ram_we_o pulses 32 times at waddr 0..31; afterwards all entries read 0.
- m_ready_i toggled 1,0,0,1 repeating -> m_data_o/m_index_o stable while stalled; no entry lost or duplicated; 32 beats total.
- start_i asserted again at beat 10 -> ignored; stream continues to index 31; exactly one done_o.
- rst_ni low at beat 5 with clear_i=1 -> outputs 0 immediately; RAM[0..4]=0 and RAM[5..31] keep their values; no done_o.
- ENTRY_NUM=5 build -> 5 beats with indices 0..4, m_last_o on index 4, rd_ptr never exceeds 4.
